// File: rtl/adder_job_sequencer.sv
// AXI4-Lite master that runs one 256-bit addition job on the serial adder slave:
// load operands, start, poll done, clear start/done, then read the eight sum words.
module adder_job_sequencer #(
    parameter int                 ADDRESS    = 32,
    parameter int                 DATA_WIDTH = 32,
    parameter logic [ADDRESS-1:0] BASE_ADDR  = '0,
    parameter int                 POLL_LIMIT = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [255:0]          op_a,
    input  logic [255:0]          op_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [255:0]          res_sum,
    output logic                  res_err,
    output logic [ADDRESS-1:0]    M_AWADDR,
    output logic                  M_AWVALID,
    input  logic                  M_AWREADY,
    output logic [DATA_WIDTH-1:0] M_WDATA,
    output logic [3:0]            M_WSTRB,
    output logic                  M_WVALID,
    input  logic                  M_WREADY,
    input  logic [1:0]            M_BRESP,
    input  logic                  M_BVALID,
    output logic                  M_BREADY,
    output logic [ADDRESS-1:0]    M_ARADDR,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RVALID,
    output logic                  M_RREADY
);
    localparam int         POLL_W    = $clog2(POLL_LIMIT + 1);
    localparam logic [4:0] REG_START = 5'd16;
    localparam logic [4:0] REG_SUM0  = 5'd17;
    localparam logic [4:0] REG_DONE  = 5'd25;

    typedef enum logic [2:0] {
        IDLE, WR_OPS, WR_START, POLL, CLR_START, CLR_DONE, RD_RES, RESP
    } state_t;

    state_t                  state, state_next;
    logic [255:0]            a_q, b_q;
    logic [511:0]            ops;
    logic [3:0]              idx;
    logic [POLL_W-1:0]       poll_cnt;
    logic                    busy;
    logic                    aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic [ADDRESS-1:0]      addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    issue, txn_read, txn_done, txn_bad, abort;
    logic [4:0]              txn_reg;
    logic [DATA_WIDTH-1:0]   txn_data;

    assign ops      = {b_q, a_q};
    assign txn_done = (b_ready && M_BVALID) || (r_ready && M_RVALID);
    assign txn_bad  = (b_ready && M_BVALID && M_BRESP != 2'b00) ||
                      (r_ready && M_RVALID && M_RRESP != 2'b00);

    assign M_AWADDR  = addr;
    assign M_ARADDR  = addr;
    assign M_WDATA   = wdata;
    assign M_WSTRB   = 4'hF;
    assign M_AWVALID = aw_valid;
    assign M_WVALID  = w_valid;
    assign M_BREADY  = b_ready;
    assign M_ARVALID = ar_valid;
    assign M_RREADY  = r_ready;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every output of this block gets a default first, otherwise the
    // paths that skip an assignment infer latches.
    always_comb begin
        state_next = state;
        job_ready  = 1'b0;
        res_valid  = 1'b0;
        txn_reg    = '0;
        txn_data   = '0;
        txn_read   = 1'b0;
        abort      = txn_bad;
        case (state)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) state_next = WR_OPS;
            end
            WR_OPS: begin
                txn_reg  = {1'b0, idx};
                txn_data = ops[{idx, 5'b0} +: DATA_WIDTH];
                if (txn_done) state_next = txn_bad ? RESP : (idx == 4'd15 ? WR_START : WR_OPS);
            end
            WR_START: begin
                txn_reg  = REG_START;
                txn_data = DATA_WIDTH'(1);
                if (txn_done) state_next = txn_bad ? RESP : POLL;
            end
            POLL: begin
                txn_reg  = REG_DONE;
                txn_read = 1'b1;
                if (txn_done) begin
                    if (txn_bad)                                   state_next = RESP;
                    else if (M_RDATA != '0)                        state_next = CLR_START;
                    else if (poll_cnt == POLL_W'(POLL_LIMIT - 1)) begin
                        state_next = RESP;
                        abort      = 1'b1;
                    end
                end
            end
            CLR_START: begin
                txn_reg = REG_START;
                if (txn_done) state_next = txn_bad ? RESP : CLR_DONE;
            end
            CLR_DONE: begin
                txn_reg = REG_DONE;
                if (txn_done) state_next = txn_bad ? RESP : RD_RES;
            end
            RD_RES: begin
                txn_reg  = 5'(REG_SUM0 + 5'(idx));
                txn_read = 1'b1;
                if (txn_done) state_next = (txn_bad || idx == 4'd7) ? RESP : RD_RES;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        issue = !busy && state != IDLE && state != RESP;
    end

    // NOTE: operand holding registers carry no reset; they are always loaded
    // on job acceptance before anything reads them.
    always_ff @(posedge ACLK) begin
        if (state == IDLE && job_valid) begin
            a_q <= op_a;
            b_q <= op_b;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            busy     <= 1'b0;
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
            b_ready  <= 1'b0;
            ar_valid <= 1'b0;
            r_ready  <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            idx      <= '0;
            poll_cnt <= '0;
            res_sum  <= '0;
            res_err  <= 1'b0;
        end else begin
            // One transaction in flight: the next issues only once busy clears.
            if (issue) begin
                busy <= 1'b1;
                addr <= BASE_ADDR + ADDRESS'({txn_reg, 2'b00});
                if (txn_read) begin
                    ar_valid <= 1'b1;
                    r_ready  <= 1'b1;
                end else begin
                    aw_valid <= 1'b1;
                    w_valid  <= 1'b1;
                    b_ready  <= 1'b1;
                    wdata    <= txn_data;
                end
            end
            if (aw_valid && M_AWREADY) aw_valid <= 1'b0;
            if (w_valid && M_WREADY)   w_valid  <= 1'b0;
            if (ar_valid && M_ARREADY) ar_valid <= 1'b0;
            if (b_ready && M_BVALID)   b_ready  <= 1'b0;
            if (r_ready && M_RVALID)   r_ready  <= 1'b0;
            if (txn_done)              busy     <= 1'b0;

            if (state_next != state) begin
                idx      <= '0;
                poll_cnt <= '0;
            end else if (txn_done) begin
                idx      <= idx + 4'd1;
                poll_cnt <= poll_cnt + POLL_W'(1);
            end

            if (state == IDLE && job_valid) begin
                res_sum <= '0;
                res_err <= 1'b0;
            end
            if (state == RD_RES && r_ready && M_RVALID && M_RRESP == 2'b00)
                res_sum[{idx[2:0], 5'b0} +: DATA_WIDTH] <= M_RDATA;
            if (abort) res_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_job_sequencer.sv
// Self-checking bench: behavioural AXI4-Lite adder slave with stalls and error
// injection, transaction-log scoreboard against a plain-arithmetic job model.
module tb_adder_job_sequencer;
    localparam int          POLL_LIMIT = 8;
    localparam logic [31:0] BASE       = 32'h0;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic         job_valid, job_ready, res_valid, res_ready, res_err;
    logic [255:0] op_a, op_b, res_sum;
    logic [31:0]  M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
    logic [3:0]   M_WSTRB;
    logic [1:0]   M_BRESP, M_RRESP;
    logic         M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic         M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

    always #5 ACLK = ~ACLK;

    adder_job_sequencer #(
        .ADDRESS(32), .DATA_WIDTH(32), .BASE_ADDR(BASE), .POLL_LIMIT(POLL_LIMIT)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .job_valid(job_valid), .job_ready(job_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_err(res_err),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    int vectors = 0;
    int miscompares = 0;

    // Slave configuration, written only by the stimulus block.
    int aw_delay = 0, w_delay = 0, r_delay = 0, polls_to_done = 1, berr_at = 0;
    bit done_never = 1'b0;

    // ---------------- behavioural AXI4-Lite adder slave ----------------
    logic [31:0] sregs [0:31];
    txn_t        log_q [$];
    int          aw_cnt, w_cnt, r_cnt, wr_count, poll_reads;
    logic        got_aw, got_w, got_ar, s_bvalid, s_rvalid;
    logic [31:0] aw_q, w_q, ar_q, s_rdata;
    logic [1:0]  s_bresp;

    assign M_AWREADY = M_AWVALID && !got_aw && (aw_cnt >= aw_delay);
    assign M_WREADY  = M_WVALID && !got_w && (w_cnt >= w_delay);
    assign M_ARREADY = M_ARVALID && !got_ar && !s_rvalid;
    assign M_BVALID  = s_bvalid;
    assign M_BRESP   = s_bresp;
    assign M_RVALID  = s_rvalid;
    assign M_RDATA   = s_rdata;
    assign M_RRESP   = 2'b00;

    function automatic int reg_index(input logic [31:0] a);
        return int'((a - BASE) >> 2) & 31;
    endfunction

    function automatic txn_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.wr = wr; t.addr = a; t.data = d;
        return t;
    endfunction

    // Word-serial ripple add over the stored operand words.
    function automatic logic [31:0] slave_sum_word(input int k);
        logic [32:0] acc;
        logic        carry;
        carry = 1'b0;
        acc   = '0;
        for (int i = 0; i <= k; i++) begin
            acc   = {1'b0, sregs[i]} + {1'b0, sregs[8+i]} + 33'(carry);
            carry = acc[32];
        end
        return acc[31:0];
    endfunction

    function automatic logic [31:0] read_value(input logic [31:0] a);
        if (reg_index(a) == 25)
            return (!done_never && poll_reads + 1 >= polls_to_done) ? 32'd1 : 32'd0;
        return sregs[reg_index(a)];
    endfunction

    always @(posedge ACLK) begin
        if (!ARESETN) begin
            got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
            s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= 2'b00; s_rdata <= '0;
            wr_count <= 0; poll_reads <= 0;
        end else begin
            if (M_AWVALID && M_AWREADY) begin
                got_aw <= 1'b1; aw_q <= M_AWADDR; aw_cnt <= 0;
            end else if (M_AWVALID && !got_aw) aw_cnt <= aw_cnt + 1;
            if (M_WVALID && M_WREADY) begin
                got_w <= 1'b1; w_q <= M_WDATA; w_cnt <= 0;
            end else if (M_WVALID && !got_w) w_cnt <= w_cnt + 1;

            if (got_aw && got_w) begin
                got_aw   <= 1'b0;
                got_w    <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= (wr_count + 1 == berr_at) ? 2'b10 : 2'b00;
                wr_count <= wr_count + 1;
                log_q.push_back(mk(1'b1, aw_q, w_q));
                sregs[reg_index(aw_q)] <= w_q;
                if (reg_index(aw_q) == 16 && w_q == 32'd1)
                    for (int k = 0; k < 8; k++) sregs[17+k] <= slave_sum_word(k);
            end
            if (s_bvalid && M_BREADY) s_bvalid <= 1'b0;

            if (M_ARVALID && M_ARREADY) begin
                got_ar <= 1'b1; ar_q <= M_ARADDR; r_cnt <= 0;
            end else if (got_ar && !s_rvalid) begin
                if (r_cnt >= r_delay) begin
                    got_ar   <= 1'b0;
                    s_rvalid <= 1'b1;
                    s_rdata  <= read_value(ar_q);
                    log_q.push_back(mk(1'b0, ar_q, read_value(ar_q)));
                    if (reg_index(ar_q) == 25) poll_reads <= poll_reads + 1;
                end else r_cnt <= r_cnt + 1;
            end
            if (s_rvalid && M_RREADY) s_rvalid <= 1'b0;

            if (job_valid && job_ready) begin
                wr_count   <= 0;
                poll_reads <= 0;
            end
        end
    end

    // ---------------- handshake-rule monitor ----------------
    int          proto_err = 0;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    // A VALID waiting for READY must hold with stable payload; after READY it must drop.
    function automatic bit hs_broken(input logic pv, pr, v, input logic [31:0] pd, d);
        return (pv && !pr && (!v || d !== pd)) || (pv && pr && v);
    endfunction

    always @(posedge ACLK) begin
        if (!ARESETN) begin
            p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
            p_awr <= 1'b0; p_wr <= 1'b0; p_arr <= 1'b0;
        end else begin
            if (hs_broken(p_awv, p_awr, M_AWVALID, p_awaddr, M_AWADDR) ||
                hs_broken(p_wv, p_wr, M_WVALID, p_wdata, M_WDATA) ||
                hs_broken(p_arv, p_arr, M_ARVALID, p_araddr, M_ARADDR) ||
                ((M_AWVALID && !p_awv) != (M_WVALID && !p_wv)) ||
                ((job_ready || res_valid) &&
                 (M_AWVALID || M_WVALID || M_ARVALID || M_BREADY || M_RREADY)) ||
                (M_WSTRB !== 4'hF))
                proto_err <= proto_err + 1;
            p_awv <= M_AWVALID; p_awr <= M_AWREADY; p_awaddr <= M_AWADDR;
            p_wv  <= M_WVALID;  p_wr  <= M_WREADY;  p_wdata  <= M_WDATA;
            p_arv <= M_ARVALID; p_arr <= M_ARREADY; p_araddr <= M_ARADDR;
        end
    end

    // ---------------- reference model and helpers ----------------
    txn_t exp_q [$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    // Expected AXI traffic of one job, from the register map and job rules.
    task automatic build_expected(input logic [255:0] a, b, input int npolls, input bit timeout);
        logic [255:0] sum;
        sum = a + b;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(1'b1, BASE + 32'(4*i), a[32*i +: 32]));
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(1'b1, BASE + 32'(32 + 4*i), b[32*i +: 32]));
        exp_q.push_back(mk(1'b1, BASE + 32'h40, 32'd1));
        if (timeout) begin
            for (int i = 0; i < POLL_LIMIT; i++) exp_q.push_back(mk(1'b0, BASE + 32'h64, 32'd0));
            return;
        end
        for (int i = 1; i <= npolls; i++)
            exp_q.push_back(mk(1'b0, BASE + 32'h64, (i == npolls) ? 32'd1 : 32'd0));
        exp_q.push_back(mk(1'b1, BASE + 32'h40, 32'd0));
        exp_q.push_back(mk(1'b1, BASE + 32'h64, 32'd0));
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(1'b0, BASE + 32'(32'h44 + 4*i), sum[32*i +: 32]));
    endtask

    task automatic compare_log(input string tag, input int base);
        check({tag, " txn count"}, 256'(log_q.size() - base), 256'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++)
            check($sformatf("%s txn %0d", tag, i), 256'(log_q[base+i]), 256'(exp_q[i]));
    endtask

    task automatic start_job(input logic [255:0] a, b, output int base);
        int n;
        @(negedge ACLK);
        base = log_q.size();
        job_valid = 1'b1; op_a = a; op_b = b;
        n = 0;
        while (!job_ready && n < 50) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        job_valid = 1'b0; op_a = rand256(); op_b = rand256();
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!res_valid && n < 4000) begin @(negedge ACLK); n++; end
        check({tag, " res_valid"}, 256'(res_valid), 256'(1));
    endtask

    task automatic accept_result(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            check($sformatf("%s held res_valid %0d", tag, i), 256'(res_valid), 256'(1));
        end
        res_ready = 1'b1;
        @(negedge ACLK);
        res_ready = 1'b0;
        check({tag, " job_ready after resp"}, 256'({job_ready, res_valid}), 256'(2'b10));
    endtask

    task automatic full_job(input string tag, input logic [255:0] a, b);
        int base;
        polls_to_done = $urandom_range(1, 6);
        build_expected(a, b, polls_to_done, 1'b0);
        start_job(a, b, base);
        wait_result(tag);
        check({tag, " sum"}, res_sum, a + b);
        check({tag, " err"}, 256'(res_err), 256'(0));
        compare_log(tag, base);
        check({tag, " protocol"}, 256'(proto_err), 256'(0));
        accept_result(tag, $urandom_range(0, 3));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        logic [255:0] a, b;
        job_valid = 1'b0; res_ready = 1'b0; op_a = '0; op_b = '0;
        ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        check("reset axi", 256'({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}), 256'(0));
        check("reset flags", 256'({job_ready, res_valid, res_err}), 256'(3'b100));
        check("reset sum", res_sum, 256'(0));
        ARESETN = 1'b1;

        full_job("basic", 256'(1), 256'(2));
        full_job("carry1", 256'(32'hFFFF_FFFF), 256'(1));
        full_job("allones", '1, '1);

        aw_delay = 3; w_delay = 5; r_delay = 4;
        full_job("stall", rand256(), rand256());

        for (int j = 0; j < 4; j++) begin
            aw_delay = $urandom_range(0, 2); w_delay = $urandom_range(0, 2); r_delay = $urandom_range(0, 2);
            full_job($sformatf("rand%0d", j), rand256(), rand256());
        end
        aw_delay = 0; w_delay = 0; r_delay = 0;

        // Done flag never rises: the poll limit aborts with no clearing writes.
        done_never = 1'b1;
        a = rand256(); b = rand256();
        build_expected(a, b, 0, 1'b1);
        start_job(a, b, base);
        wait_result("timeout");
        check("timeout err", 256'(res_err), 256'(1));
        compare_log("timeout", base);
        accept_result("timeout", 1);
        done_never = 1'b0;

        // Slave error on the fifth operand write; result held back for 10 cycles.
        berr_at = 5;
        a = rand256(); b = rand256();
        build_expected(a, b, 1, 1'b0);
        while (exp_q.size() > 5) void'(exp_q.pop_back());
        start_job(a, b, base);
        wait_result("berr");
        check("berr err", 256'(res_err), 256'(1));
        accept_result("berr", 10);
        compare_log("berr", base);
        check("berr protocol", 256'(proto_err), 256'(0));
        berr_at = 0;

        // Reset while the result words are being read back.
        polls_to_done = 2;
        a = rand256(); b = rand256();
        start_job(a, b, base);
        for (int n = 0; n < 2000 && log_q.size() < base + 23; n++) @(negedge ACLK);
        check("reset point reached", 256'(log_q.size() >= base + 23), 256'(1));
        ARESETN = 1'b0;
        @(negedge ACLK);
        check("midjob reset axi", 256'({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}), 256'(0));
        check("midjob reset ready", 256'({job_ready, res_valid}), 256'(2'b10));
        ARESETN = 1'b1;
        full_job("after reset", rand256(), rand256());

        check("final protocol", 256'(proto_err), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_job_sequencer.md
Name: adder_job_sequencer

Overview:
AXI4-Lite master that runs one complete 256-bit addition job on the serial adder slave, with no CPU involvement per word.
- Accepts a job (A, B) on a valid/ready interface.
- Writes operands into the slave, starts it, polls its done flag, clears start and done, then reads the eight result words.
- Returns the sum on a valid/ready result interface.
- Sits between a local requester (DMA or accelerator front-end) and the adder's AXI4-Lite slave port.

Parameters:
ADDRESS, 32, AXI address width
DATA_WIDTH, 32, AXI data width (fixed 32; the 256-bit operands map to 8 words)
BASE_ADDR, 32'h0, byte address of slave register 0
POLL_LIMIT, 1024, maximum number of done-flag reads before the job is aborted

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous active-low reset
job_valid  in  1  job request
job_ready  out  1  sequencer can accept a job (high only in IDLE)
op_a  in  256  operand A, word k = op_a[32k+:32]
op_b  in  256  operand B
res_valid  out  1  result available
res_ready  in  1  result consumed
res_sum  out  256  sum, word k from slave register 17+k
res_err  out  1  job aborted: non-OKAY response or poll timeout
M_AWADDR  out  ADDRESS  write address
M_AWVALID  out  1  write address valid
M_AWREADY  in  1  write address ready
M_WDATA  out  32  write data
M_WSTRB  out  4  always 4'hF
M_WVALID  out  1  write data valid
M_WREADY  in  1  write data ready
M_BRESP  in  2  write response
M_BVALID  in  1  write response valid
M_BREADY  out  1  write response ready
M_ARADDR  out  ADDRESS  read address
M_ARVALID  out  1  read address valid
M_ARREADY  in  1  read address ready
M_RDATA  in  32  read data
M_RRESP  in  2  read response
M_RVALID  in  1  read data valid
M_RREADY  out  1  read data ready

Behaviour:
Reset (ARESETN low at a rising ACLK edge):
- All VALID/READY outputs go 0, res_sum=0, res_err=0, counters=0, state=IDLE.
- Reset applies mid-job too: any outstanding AXI transaction is abandoned with no completion.

Job acceptance:
- job_ready=1 only in IDLE.
- The handshake job_valid&&job_ready registers op_a and op_b internally.
- Operand inputs are don't-care after acceptance.

Register map (word index, byte address = BASE_ADDR+4*idx):
- 0..7 A; 8..15 B; 16 start; 17..24 sum; 25 done flag.

States, in order:
- IDLE: wait for a job.
- WR_OPS: 16 writes, idx 0..15, data A words then B words, ascending.
- WR_START: write 1 to reg 16.
- POLL: read reg 25. Nonzero -> CLR_START. Zero -> re-read.
- CLR_START: write 0 to reg 16.
- CLR_DONE: write 0 to reg 25.
- RD_RES: 8 reads, reg 17..24 into res_sum word 0..7.
- RESP: hold res_valid=1 until res_ready, then go to IDLE.

Write transaction:
- AWVALID and WVALID rise in the same cycle with stable address and data.
- Each VALID drops independently the cycle after its own READY is seen.
- BREADY=1 from issue until BVALID is seen; the next transaction issues no earlier than the cycle after B completes.
- One transaction is outstanding at most.

Read transaction:
- ARVALID is held until ARREADY.
- RREADY=1 until RVALID; RDATA is captured on RVALID&&RREADY.

Errors:
- Any BRESP/RRESP != 2'b00 aborts: go to RESP with res_err=1; res_sum keeps the words captured so far.
- POLL_LIMIT consecutive zero reads of reg 25 abort with res_err=1.
- An abort skips CLR_START and CLR_DONE; the start bit may remain set in the slave.

Timing and ordering:
- Poll counter resets on entry to POLL.
- No AXI activity in IDLE or RESP.
- res_err and res_sum are valid while res_valid=1.
- Minimum job latency is 28 AXI transactions plus RESP; each transaction takes at least 2 cycles with zero-wait slave.

Test Plan:
- A=1 in word0, B=2 in word0, others 0; ideal slave model -> 16 op writes with addresses 0x00..0x3C, write 1 to 0x40, polls to 0x64, write 0 to 0x40, write 0 to 0x64, reads 0x44..0x60; res_sum word0=3, res_err=0.
- Carry chain: A word0=0xFFFFFFFF, B word0=1 -> res_sum word0=0, word1=1; A=B=all-ones -> res_sum=256'h...FFFE (low word 0xFFFFFFFE, others 0xFFFFFFFF).
- Slave stalls: AWREADY 3 cycles late, WREADY 5 cycles late, RVALID 4 cycles late -> VALIDs held stable, each VALID drops exactly once after its READY, same final result.
- Done never set, POLL_LIMIT=8 -> exactly 8 reads of 0x64, then res_valid=1, res_err=1, no CLR writes issued.
- BRESP=2'b10 on the 5th operand write -> no further AXI traffic, res_valid=1, res_err=1; res_ready held low 10 cycles -> res_valid stays 1, then job_ready=1 the cycle after the handshake.
- ARESETN low during RD_RES -> all AXI VALIDs 0 next cycle, job_ready=1; next job completes correctly.
